// File: rtl/openip_stream_upsizer_if.sv
// Narrow-in / wide-out stream bundle for openip_stream_upsizer.
interface openip_stream_upsizer_if #(
   parameter int unsigned IN_WIDTH = 8,
   parameter int unsigned RATIO    = 4
);
   logic                        w_valid;
   logic                        w_ready;
   logic [IN_WIDTH-1:0]         w_data;
   logic                        w_last;
   logic                        r_valid;
   logic                        r_ready;
   logic [IN_WIDTH*RATIO-1:0]   r_data;
   logic [RATIO-1:0]            r_keep;
   logic                        r_last;

   // Producer of narrow beats and consumer of wide words.
   modport master (
      output w_valid, w_data, w_last, r_ready,
      input  w_ready, r_valid, r_data, r_keep, r_last
   );

   // The upsizer itself.
   modport slave (
      input  w_valid, w_data, w_last, r_ready,
      output w_ready, r_valid, r_data, r_keep, r_last
   );
endinterface

// File: rtl/openip_stream_upsizer.sv
// Valid/ready width converter: packs RATIO narrow beats into one registered
// wide word, lane 0 first. w_last closes a partial word early with a keep mask.
module openip_stream_upsizer #(
   parameter int unsigned IN_WIDTH = 8,
   parameter int unsigned RATIO    = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   openip_stream_upsizer_if.slave bus
);
   localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int unsigned IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

   typedef enum logic [0:0] {StFill, StFull} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [OUT_WIDTH-1:0]   data_q, data_d;
   logic [RATIO-1:0]       keep_q, keep_d;
   logic                   last_q, last_d;

   logic                   w_ready;
   logic                   accept;
   logic                   consume;
   logic                   last_lane;

   // While a word is held, a new beat may only enter when that word leaves.
   assign w_ready   = (state_q == StFill) ? 1'b1 : bus.r_ready;
   assign accept    = bus.w_valid && w_ready;
   assign consume   = (state_q == StFull) && bus.r_ready;
   assign last_lane = (idx_q == IDX_W'(RATIO - 1));

   assign bus.w_ready = w_ready;
   assign bus.r_valid = (state_q == StFull);
   assign bus.r_data  = data_q;
   assign bus.r_keep  = keep_q;
   assign bus.r_last  = last_q;

   // State and word registers; reset discards any partial word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StFill;
         idx_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
      end
   end

   // Next-state: fill lanes in order, close on the final lane or w_last.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      unique case (state_q)
         StFill: begin
            if (accept) begin
               for (int unsigned k = 0; k < RATIO; k++) begin
                  if (idx_q == IDX_W'(k)) begin
                     data_d[k*IN_WIDTH +: IN_WIDTH] = bus.w_data;
                     keep_d[k]                      = 1'b1;
                  end
               end
               if (last_lane || bus.w_last) begin
                  state_d = StFull;
                  last_d  = bus.w_last;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         StFull: begin
            if (consume) begin
               state_d = StFill;
               data_d  = '0;
               keep_d  = '0;
               last_d  = 1'b0;
               idx_d   = '0;
               // A beat arriving alongside the consume starts a fresh word,
               // so full-rate streaming sees no bubble.
               if (accept) begin
                  data_d[IN_WIDTH-1:0] = bus.w_data;
                  keep_d[0]            = 1'b1;
                  if ((RATIO == 1) || bus.w_last) begin
                     state_d = StFull;
                     last_d  = bus.w_last;
                  end else begin
                     idx_d = IDX_W'(1);
                  end
               end
            end
         end
         default: state_d = StFill;
      endcase
   end
endmodule

// File: tb/tb_openip_stream_upsizer.sv
// Self-checking bench: directed literal cases plus randomized traffic for
// RATIO=4 and RATIO=1 instances, checked against queue-based word models.
module tb_openip_stream_upsizer;
   logic clk;
   logic rstn;
   logic rstn1;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   openip_stream_upsizer_if #(.IN_WIDTH(8), .RATIO(4)) b4 ();
   openip_stream_upsizer_if #(.IN_WIDTH(8), .RATIO(1)) b1 ();

   openip_stream_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut4 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (b4)
   );

   openip_stream_upsizer #(.IN_WIDTH(8), .RATIO(1)) dut1 (
      .clk  (clk),
      .rstn (rstn1),
      .bus  (b1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- RATIO=4 model: partial word + queue of closed words
   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } word_t;

   word_t       q4[$];
   logic [31:0] p_data;
   logic [3:0]  p_keep;
   int          p_idx;
   int          words4 = 0;

   always @(negedge clk) begin
      if (!rstn) begin
         q4.delete();
         p_data = '0;
         p_keep = '0;
         p_idx  = 0;
         chk("rst_r_valid", 64'(b4.r_valid), 64'd0);
         chk("rst_r_data", 64'(b4.r_data), 64'd0);
         chk("rst_r_keep", 64'(b4.r_keep), 64'd0);
         chk("rst_r_last", 64'(b4.r_last), 64'd0);
      end else begin
         logic exp_wr;
         exp_wr = (q4.size() == 0) || b4.r_ready;
         chk("w_ready", 64'(b4.w_ready), 64'(exp_wr));
         chk("r_valid", 64'(b4.r_valid), 64'(q4.size() != 0));
         if (q4.size() != 0) begin
            chk("r_data", 64'(b4.r_data), 64'(q4[0].d));
            chk("r_keep", 64'(b4.r_keep), 64'(q4[0].k));
            chk("r_last", 64'(b4.r_last), 64'(q4[0].l));
            if (b4.r_ready) begin
               void'(q4.pop_front());
               words4++;
            end
         end
         if (b4.w_valid && exp_wr) begin
            p_data[p_idx*8 +: 8] = b4.w_data;
            p_keep[p_idx]        = 1'b1;
            p_idx++;
            if (p_idx == 4 || b4.w_last) begin
               q4.push_back('{d: p_data, k: p_keep, l: b4.w_last});
               p_data = '0;
               p_keep = '0;
               p_idx  = 0;
            end
         end
      end
   end

   // ---------------- RATIO=1 model: every accepted beat is one word
   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   beat_t q1[$];

   always @(negedge clk) begin
      if (!rstn1) begin
         q1.delete();
      end else begin
         logic exp_wr;
         exp_wr = (q1.size() == 0) || b1.r_ready;
         chk("r1_w_ready", 64'(b1.w_ready), 64'(exp_wr));
         chk("r1_r_valid", 64'(b1.r_valid), 64'(q1.size() != 0));
         if (q1.size() != 0) begin
            chk("r1_r_data", 64'(b1.r_data), 64'(q1[0].d));
            chk("r1_r_keep", 64'(b1.r_keep), 64'd1);
            chk("r1_r_last", 64'(b1.r_last), 64'(q1[0].l));
            if (b1.r_ready) void'(q1.pop_front());
         end
         if (b1.w_valid && exp_wr) q1.push_back('{d: b1.w_data, l: b1.w_last});
      end
   end

   // ---------------- RATIO=4 driver helpers
   logic acc4;
   logic rand4 = 1'b0;
   int   ticks4 = 0;

   task automatic tick4();
      @(negedge clk);
      acc4 = b4.w_valid && b4.w_ready;
      @(posedge clk);
      #1;
      ticks4++;
      if (rand4) b4.r_ready = ($urandom_range(0, 2) != 0);
   endtask

   task automatic send4(input logic [7:0] d, input logic l);
      int n;
      b4.w_valid = 1'b1;
      b4.w_data  = d;
      b4.w_last  = l;
      n = 0;
      do begin
         tick4();
         n++;
      end while (!acc4 && n < 200);
      if (!acc4) chk("send4_timeout", 64'd0, 64'd1);
   endtask

   task automatic sync4();
      @(posedge clk);
      #1;
   endtask

   // ---------------- RATIO=1 stimulus
   logic done1 = 1'b0;

   initial begin
      logic acc1;
      int   n;
      b1.w_valid = 1'b0;
      b1.w_data  = '0;
      b1.w_last  = 1'b0;
      b1.r_ready = 1'b0;
      rstn1 = 1'b1;
      #1 rstn1 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn1 = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            b1.w_valid = 1'b0;
            @(posedge clk);
            #1 b1.r_ready = $urandom_range(0, 1);
         end
         b1.w_valid = 1'b1;
         b1.w_data  = 8'($urandom);
         b1.w_last  = ($urandom_range(0, 2) == 0);
         n = 0;
         do begin
            @(negedge clk);
            acc1 = b1.w_valid && b1.w_ready;
            @(posedge clk);
            #1 b1.r_ready = $urandom_range(0, 1);
            n++;
         end while (!acc1 && n < 200);
         if (!acc1) chk("send1_timeout", 64'd0, 64'd1);
      end
      b1.w_valid = 1'b0;
      b1.r_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("r1_drained", 64'(q1.size()), 64'd0);
      done1 = 1'b1;
   end

   // ---------------- RATIO=4 directed + random sequence
   initial begin
      int w0;
      int t0;
      b4.w_valid = 1'b0;
      b4.w_data  = '0;
      b4.w_last  = 1'b0;
      b4.r_ready = 1'b1;
      rstn = 1'b1;
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_w_ready", 64'(b4.w_ready), 64'd1);
      sync4();

      // Full word, presented one cycle after the fourth beat.
      send4(8'h11, 1'b0);
      send4(8'h22, 1'b0);
      send4(8'h33, 1'b0);
      send4(8'h44, 1'b0);
      b4.w_valid = 1'b0;
      @(negedge clk);
      chk("t1_valid", 64'(b4.r_valid), 64'd1);
      chk("t1_data", 64'(b4.r_data), 64'h44332211);
      chk("t1_keep", 64'(b4.r_keep), 64'hf);
      chk("t1_last", 64'(b4.r_last), 64'd0);
      sync4();

      // Early flush by w_last, then next packet restarts at lane 0.
      send4(8'hAA, 1'b0);
      send4(8'hBB, 1'b1);
      b4.w_valid = 1'b0;
      @(negedge clk);
      chk("t2_data", 64'(b4.r_data), 64'h0000BBAA);
      chk("t2_keep", 64'(b4.r_keep), 64'h3);
      chk("t2_last", 64'(b4.r_last), 64'd1);
      sync4();
      send4(8'h77, 1'b1);
      b4.w_valid = 1'b0;
      @(negedge clk);
      chk("t2b_data", 64'(b4.r_data), 64'h00000077);
      chk("t2b_keep", 64'(b4.r_keep), 64'h1);
      chk("t2b_last", 64'(b4.r_last), 64'd1);
      sync4();

      // Twelve beats at full rate: three words, no stall cycles.
      w0 = words4;
      t0 = ticks4;
      for (int i = 0; i < 12; i++) send4(8'(8'h80 + i), 1'b0);
      chk("t3_ticks", 64'(ticks4 - t0), 64'd12);
      b4.w_valid = 1'b0;
      tick4();
      tick4();
      chk("t3_words", 64'(words4 - w0), 64'd3);

      // Backpressure: held word stays stable, pending beat waits.
      b4.r_ready = 1'b0;
      send4(8'hA0, 1'b0);
      send4(8'hA1, 1'b0);
      send4(8'hA2, 1'b0);
      send4(8'hA3, 1'b0);
      b4.w_valid = 1'b1;
      b4.w_data  = 8'h55;
      b4.w_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_w_ready", 64'(b4.w_ready), 64'd0);
         chk("t4_data", 64'(b4.r_data), 64'hA3A2A1A0);
         chk("t4_keep", 64'(b4.r_keep), 64'hf);
         chk("t4_last", 64'(b4.r_last), 64'd0);
         sync4();
      end
      b4.r_ready = 1'b1;
      @(negedge clk);
      chk("t4_release_w_ready", 64'(b4.w_ready), 64'd1);
      sync4();
      b4.w_valid = 1'b0;
      b4.w_last  = 1'b0;
      @(negedge clk);
      chk("t4_next_data", 64'(b4.r_data), 64'h00000055);
      chk("t4_next_keep", 64'(b4.r_keep), 64'h1);
      chk("t4_next_last", 64'(b4.r_last), 64'd1);
      sync4();

      // Reset mid-word: outputs clear at once, no stale lanes afterwards.
      send4(8'hE1, 1'b0);
      send4(8'hE2, 1'b0);
      b4.w_valid = 1'b0;
      rstn = 1'b0;
      #1;
      chk("t5_rst_valid", 64'(b4.r_valid), 64'd0);
      chk("t5_rst_keep", 64'(b4.r_keep), 64'd0);
      sync4();
      rstn = 1'b1;
      send4(8'h01, 1'b0);
      send4(8'h02, 1'b0);
      send4(8'h03, 1'b0);
      send4(8'h04, 1'b0);
      b4.w_valid = 1'b0;
      @(negedge clk);
      chk("t5_data", 64'(b4.r_data), 64'h04030201);
      chk("t5_keep", 64'(b4.r_keep), 64'hf);
      sync4();

      // Randomized traffic against the model.
      rand4 = 1'b1;
      for (int i = 0; i < 300; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            b4.w_valid = 1'b0;
            tick4();
         end
         send4(8'($urandom), ($urandom_range(0, 4) == 0));
      end
      b4.w_valid = 1'b0;
      rand4 = 1'b0;
      b4.r_ready = 1'b1;
      tick4();
      tick4();
      @(negedge clk);
      chk("t6_r_valid_idle", 64'(b4.r_valid), 64'(q4.size() != 0));

      wait (done1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end
endmodule
